core_alu_seq: RTL and testbench

- Multi-cycle, width-parametrised successor to the combinational 8-bit core ALU.
- Processes WIDTH-bit operands serially, SLICE bits per clock, with the carry/shift bit chained between slices; full-width N/V/Z/C flags are produced on completion.
- Sits beside the core datapath for 16-bit address/pointer arithmetic and wide shifts.
- Connects over a valid/ready handshake on both sides.

---
 rtl/core_alu_seq_pkg.sv | 48 ++++
 rtl/core_alu_slice.sv | 108 ++++++++++
 rtl/core_alu_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_core_alu_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/core_alu_seq_pkg.sv
// Shared types and decode helpers for the serial core ALU (core_alu_seq).
package core_alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_PASS_L = 4'd0,
    OP_PASS_R = 4'd1,
    OP_ADC    = 4'd2,
    OP_SBC    = 4'd3,
    OP_AND    = 4'd4,
    OP_OR     = 4'd5,
    OP_XOR    = 4'd6,
    OP_ASL    = 4'd7,
    OP_ROL    = 4'd8,
    OP_LSR    = 4'd9,
    OP_ROR    = 4'd10,
    OP_CMP    = 4'd11,
    OP_BIT    = 4'd12,
    OP_RSV13  = 4'd13,
    OP_RSV14  = 4'd14,
    OP_RSV15  = 4'd15
  } op_type;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_type;

  function automatic logic is_reserved_op(input op_type op);
    return (op == OP_RSV13) || (op == OP_RSV14) || (op == OP_RSV15);
  endfunction

  // Right shifts walk the operand from the top slice down so the shifted-out bit chains downward.
  function automatic logic is_msb_first(input op_type op);
    return (op == OP_LSR) || (op == OP_ROR);
  endfunction

  function automatic logic chain_init(input op_type op, input logic carry);
    logic bit_s;
    case (op)
      OP_ADC, OP_SBC, OP_ROL, OP_ROR: bit_s = carry;
      OP_CMP:                         bit_s = 1'b1;
      default:                        bit_s = 1'b0;
    endcase
    return bit_s;
  endfunction

endpackage

// File: rtl/core_alu_slice.sv
// Combinational SLICE-bit datapath of core_alu_seq; the packed-BCD adjust exists only
// when CORE_ALU_SEQ_DECIMAL_EN is defined.
module core_alu_slice
  import core_alu_seq_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  op_type           op,
  input  logic [SLICE-1:0] lhs,
  input  logic [SLICE-1:0] rhs,
  input  logic             chain_in,
  input  logic             decimal,
  output logic [SLICE-1:0] result,
  output logic             chain_out,
  output logic             overflow
);

  logic [SLICE-1:0] rhs_eff_s;
  logic [SLICE:0]   sum_s;
  logic [SLICE-1:0] arith_res_s;
  logic             arith_cout_s;

`ifdef CORE_ALU_SEQ_DECIMAL_EN
  logic [SLICE-1:0] dec_res_s;
  logic             dec_cout_s;
  logic [4:0]       nib_s;
  logic             dc_s;
`else
  logic             unused_decimal_s;
  assign unused_decimal_s = decimal;
`endif

  assign rhs_eff_s = ((op == OP_SBC) || (op == OP_CMP)) ? ~rhs : rhs;
  assign sum_s     = {1'b0, lhs} + {1'b0, rhs_eff_s} + {{SLICE{1'b0}}, chain_in};

`ifdef CORE_ALU_SEQ_DECIMAL_EN
  // Per-nibble BCD: subtraction reuses the complemented-rhs adder, so a missing nibble carry means borrow.
  always_comb begin
    dc_s      = chain_in;
    dec_res_s = '0;
    nib_s     = 5'd0;
    for (int i = 0; i < SLICE / 4; i++) begin
      nib_s = {1'b0, lhs[4*i +: 4]} + {1'b0, rhs_eff_s[4*i +: 4]} + {4'd0, dc_s};
      if (op == OP_SBC) begin
        if (nib_s[4]) begin
          dc_s                 = 1'b1;
          dec_res_s[4*i +: 4]  = nib_s[3:0];
        end else begin
          dc_s                 = 1'b0;
          dec_res_s[4*i +: 4]  = nib_s[3:0] - 4'd6;
        end
      end else begin
        if (nib_s > 5'd9) begin
          dc_s                 = 1'b1;
          dec_res_s[4*i +: 4]  = nib_s[3:0] + 4'd6;
        end else begin
          dc_s                 = 1'b0;
          dec_res_s[4*i +: 4]  = nib_s[3:0];
        end
      end
    end
    dec_cout_s = dc_s;
  end

  always_comb begin
    if (decimal && ((op == OP_ADC) || (op == OP_SBC))) begin
      arith_res_s  = dec_res_s;
      arith_cout_s = dec_cout_s;
    end else begin
      arith_res_s  = sum_s[SLICE-1:0];
      arith_cout_s = sum_s[SLICE];
    end
  end
`else
  assign arith_res_s  = sum_s[SLICE-1:0];
  assign arith_cout_s = sum_s[SLICE];
`endif

  assign overflow = (lhs[SLICE-1] == rhs_eff_s[SLICE-1]) && (arith_res_s[SLICE-1] != lhs[SLICE-1]);

  always_comb begin
    result    = lhs;
    chain_out = chain_in;
    case (op)
      OP_PASS_R: result = rhs;
      OP_ADC, OP_SBC, OP_CMP: begin
        result    = arith_res_s;
        chain_out = arith_cout_s;
      end
      OP_AND: result = lhs & rhs;
      OP_OR:  result = lhs | rhs;
      OP_XOR: result = lhs ^ rhs;
      OP_ASL, OP_ROL: begin
        result    = {lhs[SLICE-2:0], chain_in};
        chain_out = lhs[SLICE-1];
      end
      OP_LSR, OP_ROR: begin
        result    = {chain_in, lhs[SLICE-1:1]};
        chain_out = lhs[0];
      end
      default: begin
        result    = lhs;
        chain_out = chain_in;
      end
    endcase
  end

endmodule

// File: rtl/core_alu_seq.sv
// Multi-cycle serial core ALU: WIDTH-bit operands processed SLICE bits per clock over a
// valid/ready handshake. Optional packed-BCD ADC/SBC under CORE_ALU_SEQ_DECIMAL_EN.
module core_alu_seq
  import core_alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 8
) (
  input  logic             I_clock,
  input  logic             I_reset,
  input  logic             I_valid,
  output logic             O_ready,
  input  logic [3:0]       I_op,
  input  logic [WIDTH-1:0] I_lhs,
  input  logic [WIDTH-1:0] I_rhs,
  input  logic             I_carry,
  input  logic             I_overflow,
  input  logic             I_sign,
  input  logic             I_zero,
  input  logic             I_decimal,
  output logic             O_valid,
  input  logic             I_ready,
  output logic [WIDTH-1:0] O_result,
  output logic             O_carry,
  output logic             O_overflow,
  output logic             O_sign,
  output logic             O_zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  state_type        state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  op_type           op_q, op_d;
  logic [WIDTH-1:0] lhs_q, lhs_d, rhs_q, rhs_d;
  logic             c_in_q, c_in_d, v_in_q, v_in_d, n_in_q, n_in_d, z_in_q, z_in_d;
  logic             chain_q, chain_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zacc_q, zacc_d;
  logic             ready_q, ready_d, valid_q, valid_d;
  logic [WIDTH-1:0] out_res_q, out_res_d;
  logic             out_c_q, out_c_d, out_v_q, out_v_d, out_n_q, out_n_d, out_z_q, out_z_d;

  logic [IDXW-1:0]  pos_s;
  logic [SLICE-1:0] slice_lhs_s, slice_rhs_s, slice_res_s;
  logic             slice_cout_s, slice_ovf_s, slice_dec_s;

`ifdef CORE_ALU_SEQ_DECIMAL_EN
  logic dec_q, dec_d;
  assign slice_dec_s = dec_q;
`else
  logic unused_decimal_s;
  assign unused_decimal_s = I_decimal;
  assign slice_dec_s      = 1'b0;
`endif

  assign pos_s       = is_msb_first(op_q) ? (LAST_IDX - idx_q) : idx_q;
  assign slice_lhs_s = lhs_q[int'(pos_s)*SLICE +: SLICE];
  assign slice_rhs_s = rhs_q[int'(pos_s)*SLICE +: SLICE];

  core_alu_slice #(.SLICE(SLICE)) u_slice (
    .op        (op_q),
    .lhs       (slice_lhs_s),
    .rhs       (slice_rhs_s),
    .chain_in  (chain_q),
    .decimal   (slice_dec_s),
    .result    (slice_res_s),
    .chain_out (slice_cout_s),
    .overflow  (slice_ovf_s)
  );

  // Next-state, operand capture, slice accumulation and completion flags.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_d      = op_q;
    lhs_d     = lhs_q;
    rhs_d     = rhs_q;
    c_in_d    = c_in_q;
    v_in_d    = v_in_q;
    n_in_d    = n_in_q;
    z_in_d    = z_in_q;
    chain_d   = chain_q;
    res_d     = res_q;
    zacc_d    = zacc_q;
    ready_d   = ready_q;
    valid_d   = valid_q;
    out_res_d = out_res_q;
    out_c_d   = out_c_q;
    out_v_d   = out_v_q;
    out_n_d   = out_n_q;
    out_z_d   = out_z_q;
`ifdef CORE_ALU_SEQ_DECIMAL_EN
    dec_d     = dec_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (I_valid) begin
          op_d    = op_type'(I_op);
          lhs_d   = I_lhs;
          rhs_d   = I_rhs;
          c_in_d  = I_carry;
          v_in_d  = I_overflow;
          n_in_d  = I_sign;
          z_in_d  = I_zero;
`ifdef CORE_ALU_SEQ_DECIMAL_EN
          dec_d   = I_decimal;
`endif
          idx_d   = '0;
          res_d   = '0;
          zacc_d  = 1'b0;
          chain_d = chain_init(op_type'(I_op), I_carry);
          ready_d = 1'b0;
          state_d = ST_RUN;
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        res_d[int'(pos_s)*SLICE +: SLICE] = slice_res_s;
        zacc_d  = zacc_q | (|slice_res_s);
        chain_d = slice_cout_s;
        if (idx_q == LAST_IDX) begin
          state_d   = ST_DONE;
          valid_d   = 1'b1;
          out_res_d = res_d;
          out_c_d   = c_in_q;
          out_v_d   = v_in_q;
          out_n_d   = n_in_q;
          out_z_d   = z_in_q;
          // The last slice processed is the MSB slice for every op that reports V.
          if (is_reserved_op(op_q)) begin
            out_c_d = c_in_q;
          end else begin
            case (op_q)
              OP_PASS_L, OP_PASS_R, OP_AND, OP_OR, OP_XOR: begin
                out_n_d = res_d[WIDTH-1];
                out_z_d = ~zacc_d;
              end
              OP_ADC, OP_SBC: begin
                out_n_d = res_d[WIDTH-1];
                out_z_d = ~zacc_d;
                out_c_d = slice_cout_s;
                out_v_d = slice_ovf_s;
              end
              OP_CMP, OP_ASL, OP_ROL, OP_LSR, OP_ROR: begin
                out_n_d = res_d[WIDTH-1];
                out_z_d = ~zacc_d;
                out_c_d = slice_cout_s;
              end
              OP_BIT: begin
                out_n_d = rhs_q[WIDTH-1];
                out_v_d = rhs_q[WIDTH-2];
                out_z_d = ~|(lhs_q & rhs_q);
              end
              default: begin
                out_c_d = c_in_q;
              end
            endcase
          end
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      ST_DONE: begin
        if (I_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      op_q      <= OP_PASS_L;
      lhs_q     <= '0;
      rhs_q     <= '0;
      c_in_q    <= 1'b0;
      v_in_q    <= 1'b0;
      n_in_q    <= 1'b0;
      z_in_q    <= 1'b0;
      chain_q   <= 1'b0;
      res_q     <= '0;
      zacc_q    <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      out_res_q <= '0;
      out_c_q   <= 1'b0;
      out_v_q   <= 1'b0;
      out_n_q   <= 1'b0;
      out_z_q   <= 1'b0;
`ifdef CORE_ALU_SEQ_DECIMAL_EN
      dec_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      lhs_q     <= lhs_d;
      rhs_q     <= rhs_d;
      c_in_q    <= c_in_d;
      v_in_q    <= v_in_d;
      n_in_q    <= n_in_d;
      z_in_q    <= z_in_d;
      chain_q   <= chain_d;
      res_q     <= res_d;
      zacc_q    <= zacc_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      out_res_q <= out_res_d;
      out_c_q   <= out_c_d;
      out_v_q   <= out_v_d;
      out_n_q   <= out_n_d;
      out_z_q   <= out_z_d;
`ifdef CORE_ALU_SEQ_DECIMAL_EN
      dec_q     <= dec_d;
`endif
    end
  end

  assign O_ready    = ready_q;
  assign O_valid    = valid_q;
  assign O_result   = out_res_q;
  assign O_carry    = out_c_q;
  assign O_overflow = out_v_q;
  assign O_sign     = out_n_q;
  assign O_zero     = out_z_q;

endmodule

// File: tb/tb_core_alu_seq.sv
// Self-checking bench for core_alu_seq: directed cases plus random ops against a full-width model.
module tb_core_alu_seq;

  localparam int W    = 16;
  localparam int S    = 8;
  localparam int LAT  = W / S + 1;
  localparam int MAXS = (1 << (W - 1)) - 1;
  localparam int MINS = -(1 << (W - 1));

  logic         I_clock = 1'b0;
  logic         I_reset, I_valid, I_ready;
  logic [3:0]   I_op;
  logic [W-1:0] I_lhs, I_rhs;
  logic         I_carry, I_overflow, I_sign, I_zero, I_decimal;
  logic         O_ready, O_valid;
  logic [W-1:0] O_result;
  logic         O_carry, O_overflow, O_sign, O_zero;

  int total = 0;
  int bad   = 0;

  core_alu_seq #(.WIDTH(W), .SLICE(S)) dut (
    .I_clock    (I_clock),
    .I_reset    (I_reset),
    .I_valid    (I_valid),
    .O_ready    (O_ready),
    .I_op       (I_op),
    .I_lhs      (I_lhs),
    .I_rhs      (I_rhs),
    .I_carry    (I_carry),
    .I_overflow (I_overflow),
    .I_sign     (I_sign),
    .I_zero     (I_zero),
    .I_decimal  (I_decimal),
    .O_valid    (O_valid),
    .I_ready    (I_ready),
    .O_result   (O_result),
    .O_carry    (O_carry),
    .O_overflow (O_overflow),
    .O_sign     (O_sign),
    .O_zero     (O_zero)
  );

  always #5 I_clock = ~I_clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge I_clock);
    #1;
  endtask

  // Reference: whole-word arithmetic, returns {C,V,N,Z,result}.
  function automatic logic [W+3:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [3:0] fin);
    logic c, v, n, z, nz, cin;
    logic [W-1:0] r, bb;
    logic [W:0] s;
    int sv;
    {c, v, n, z} = fin;
    r = a; nz = 1'b1; bb = b; cin = c;
    case (op)
      4'd0: r = a;
      4'd1: r = b;
      4'd2, 4'd3, 4'd11: begin
        if (op != 4'd2) bb = ~b;
        if (op == 4'd11) cin = 1'b1;
        s = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
        r = s[W-1:0];
        c = s[W];
        if (op != 4'd11) begin
          sv = int'($signed(a)) + int'($signed(bb)) + int'(cin);
          v  = (sv > MAXS) || (sv < MINS);
        end
      end
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: begin r = a << 1; c = a[W-1]; end
      4'd8: begin r = {a[W-2:0], fin[3]}; c = a[W-1]; end
      4'd9: begin r = a >> 1; c = a[0]; end
      4'd10: begin r = {fin[3], a[W-1:1]}; c = a[0]; end
      4'd12: begin nz = 1'b0; n = b[W-1]; v = b[W-2]; z = ((a & b) == '0); end
      default: nz = 1'b0;
    endcase
    if (nz) begin
      n = r[W-1];
      z = (r == '0);
    end
    return {c, v, n, z, r};
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] fin, input logic dec, input int hold,
                        output logic [W-1:0] r_obs, output logic [3:0] f_obs);
    logic [W+3:0] exp;
    int n, lat;
    n = 0;
    while (!O_ready && n < 20) begin step(); n++; end
    check_eq("ready_before_accept", 32'(O_ready), 32'd1);
    I_op = op; I_lhs = a; I_rhs = b; {I_carry, I_overflow, I_sign, I_zero} = fin;
    I_decimal = dec; I_valid = 1'b1; I_ready = 1'b0;
    step();
    I_valid = 1'b0;
    I_op = 4'($urandom); I_lhs = W'($urandom); I_rhs = W'($urandom);
    {I_carry, I_overflow, I_sign, I_zero} = 4'($urandom);
    lat = 1;
    while (!O_valid && lat < 20) begin step(); lat++; end
    check_eq($sformatf("latency op%0d", op), 32'(lat), 32'(LAT));
    r_obs = O_result;
    f_obs = {O_carry, O_overflow, O_sign, O_zero};
    if (!dec) begin
      exp = model(op, a, b, fin);
      check_eq($sformatf("result op%0d a=%h b=%h", op, a, b), 32'(r_obs), 32'(exp[W-1:0]));
      check_eq($sformatf("flags op%0d a=%h b=%h f=%b", op, a, b, fin), 32'(f_obs), 32'(exp[W+3:W]));
    end
    for (int k = 0; k < hold; k++) begin
      step();
      check_eq("hold_valid", 32'(O_valid), 32'd1);
      check_eq("hold_result", 32'(O_result), 32'(r_obs));
      check_eq("hold_flags", 32'({O_carry, O_overflow, O_sign, O_zero}), 32'(f_obs));
      check_eq("hold_ready", 32'(O_ready), 32'd0);
    end
    I_ready = 1'b1;
    step();
    I_ready = 1'b0;
    check_eq("consume_valid", 32'(O_valid), 32'd0);
  endtask

  logic [W-1:0] r;
  logic [3:0]   f;
  logic [W-1:0] pick [6] = '{16'h0000, 16'hFFFF, 16'h00FF, 16'h8000, 16'h7FFF, 16'h0100};

  initial begin
    I_reset = 1'b1; I_valid = 1'b0; I_ready = 1'b0; I_op = 4'd0;
    I_lhs = '0; I_rhs = '0; I_carry = 1'b0; I_overflow = 1'b0; I_sign = 1'b0;
    I_zero = 1'b0; I_decimal = 1'b0;
    step(); step();
    I_reset = 1'b0;
    check_eq("reset_valid", 32'(O_valid), 32'd0);
    check_eq("reset_ready", 32'(O_ready), 32'd1);
    check_eq("reset_result", 32'(O_result), 32'd0);
    check_eq("reset_flags", 32'({O_carry, O_overflow, O_sign, O_zero}), 32'd0);

    run_op(4'd2, 16'h00FF, 16'h0001, 4'b0000, 1'b0, 0, r, f);
    check_eq("adc_cross_result", 32'(r), 32'h0100);
    check_eq("adc_cross_flags", 32'(f), 32'b0000);
    run_op(4'd3, 16'h8000, 16'h0001, 4'b1000, 1'b0, 0, r, f);
    check_eq("sbc_result", 32'(r), 32'h7FFF);
    check_eq("sbc_flags", 32'(f), 32'b1100);
    run_op(4'd10, 16'h0001, 16'h0000, 4'b1000, 1'b0, 0, r, f);
    check_eq("ror_result", 32'(r), 32'h8000);
    check_eq("ror_flags", 32'(f), 32'b1010);
    run_op(4'd9, 16'h0100, 16'h0000, 4'b0000, 1'b0, 0, r, f);
    check_eq("lsr_result", 32'(r), 32'h0080);
    check_eq("lsr_flags", 32'(f), 32'b0000);
    run_op(4'd12, 16'h00F0, 16'hC00F, 4'b0000, 1'b0, 5, r, f);
    check_eq("bit_result", 32'(r), 32'h00F0);
    check_eq("bit_flags", 32'(f), 32'b0111);
    run_op(4'd11, 16'h1234, 16'h1234, 4'b0100, 1'b0, 0, r, f);
    check_eq("cmp_eq_flags", 32'(f), 32'b1101);
    run_op(4'd14, 16'hABCD, 16'h0000, 4'b1011, 1'b0, 0, r, f);
    check_eq("rsv_flags", 32'(f), 32'b1011);

`ifdef CORE_ALU_SEQ_DECIMAL_EN
    run_op(4'd2, 16'h0999, 16'h0001, 4'b0000, 1'b1, 0, r, f);
    check_eq("dec_adc_result", 32'(r), 32'h1000);
    check_eq("dec_adc_carry", 32'(f[3]), 32'd0);
    run_op(4'd3, 16'h1000, 16'h0001, 4'b1000, 1'b1, 0, r, f);
    check_eq("dec_sbc_result", 32'(r), 32'h0999);
    check_eq("dec_sbc_carry", 32'(f[3]), 32'd1);
`endif

    for (int i = 0; i < 80; i++) begin
      logic [W-1:0] a, b;
      logic dec;
      a = ($urandom_range(3, 0) == 0) ? pick[$urandom_range(5, 0)] : W'($urandom);
      b = ($urandom_range(3, 0) == 0) ? pick[$urandom_range(5, 0)] : W'($urandom);
`ifdef CORE_ALU_SEQ_DECIMAL_EN
      dec = 1'b0;
`else
      dec = 1'($urandom);
`endif
      run_op(4'($urandom), a, b, 4'($urandom), dec, (i % 16 == 0) ? 2 : 0, r, f);
    end

    // Abort an operation mid-RUN after a nonzero result is on the outputs.
    run_op(4'd1, 16'h5A5A, 16'hBEEF, 4'b0000, 1'b0, 0, r, f);
    I_op = 4'd2; I_lhs = 16'h1111; I_rhs = 16'h2222; I_valid = 1'b1;
    step();
    I_valid = 1'b0;
    step();
    I_reset = 1'b1;
    step();
    I_reset = 1'b0;
    check_eq("abort_valid", 32'(O_valid), 32'd0);
    check_eq("abort_result", 32'(O_result), 32'd0);
    check_eq("abort_ready", 32'(O_ready), 32'd1);
    check_eq("abort_flags", 32'({O_carry, O_overflow, O_sign, O_zero}), 32'd0);
    run_op(4'd5, 16'h0F00, 16'h00F0, 4'b0000, 1'b0, 0, r, f);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
